// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch request path.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } fetch_entry_t;

    localparam logic [31:0] BOOT_OFFSET_DEFAULT = 32'h80;

endpackage

// File: rtl/if_fetch_fifo.sv
// Response buffer: shift-register FIFO whose head is always entry 0, so the
// head output comes straight from a register.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  wdata_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t [DEPTH-1:0] mem, mem_nxt;
    logic [CW-1:0]            count, count_nxt;
    logic                     full, do_pop, do_push;

    always_comb begin
        full      = (count == CW'(DEPTH));
        do_pop    = pop_i && (count != '0);
        do_push   = push_i && (!full || do_pop);
        mem_nxt   = do_pop ? (mem >> $bits(fetch_entry_t)) : mem;
        // Write slot is computed after the shift so push+pop at full lands in the last entry.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (do_push && (CW'(i) == count - CW'(do_pop))) begin
                mem_nxt[i] = wdata_i;
            end
        end
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem   <= '0;
            count <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else begin
            mem   <= mem_nxt;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            assert (!(push_i && full && !do_pop))
            else $error("if_fetch_fifo: push into full buffer without pop");
        end
    end

    assign head_o  = mem[0];
    assign count_o = count;

endmodule

// File: rtl/if_fetch_req.sv
// IF-stage request side: word-aligned address generation, req/gnt/rvalid
// handshake with credit limiting, redirect with stale-response discard.
module if_fetch_req
    import if_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter logic [31:0] BOOT_OFFSET = BOOT_OFFSET_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_enable_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_rdata_o,
    output logic [31:0] fetch_addr_o,
    output logic        fetch_err_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state;
    logic [31:0]   req_pc, resp_pc, pend_addr, boot_pc, branch_tgt;
    logic          pend_valid, req_held;
    logic [CW-1:0] outstanding, outstanding_nxt, discard_cnt, fifo_count;
    logic          credit_ok, gnt_fire, held_now, rsp_ok, redirect, push, pop;
    fetch_entry_t  push_entry, head;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{boot_addr_i[7:0], branch_addr_i[1:0]};

    always_comb begin
        boot_pc         = {boot_addr_i[31:8], 8'h00} + BOOT_OFFSET;
        branch_tgt      = {branch_addr_i[31:2], 2'b00};
        credit_ok       = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
        // A request left ungranted stays up regardless of credit or state changes.
        instr_req_o     = req_held || ((state == RUN) && credit_ok);
        instr_addr_o    = (state == IDLE) ? boot_pc : req_pc;
        gnt_fire        = instr_req_o && instr_gnt_i;
        held_now        = instr_req_o && !instr_gnt_i;
        rsp_ok          = instr_rvalid_i && (outstanding != '0);
        outstanding_nxt = outstanding + CW'(gnt_fire) - CW'(rsp_ok);
        redirect        = branch_i && (state != IDLE);
        push            = rsp_ok && (discard_cnt == '0) && !redirect;
        push_entry      = '{rdata: instr_rdata_i, addr: resp_pc, err: instr_err_i};
        fetch_valid_o   = (fifo_count != '0);
        pop             = fetch_valid_o && fetch_ready_i && !branch_i;
        fetch_rdata_o   = head.rdata;
        fetch_addr_o    = head.addr;
        fetch_err_o     = head.err;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            req_pc      <= '0;
            resp_pc     <= '0;
            pend_addr   <= '0;
            pend_valid  <= 1'b0;
            req_held    <= 1'b0;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            req_held    <= held_now;
            outstanding <= outstanding_nxt;
            if (state == IDLE) begin
                if (fetch_enable_i) begin
                    state   <= RUN;
                    req_pc  <= boot_pc;
                    resp_pc <= boot_pc;
                end
            end else begin
                if (gnt_fire) begin
                    req_pc     <= pend_valid ? pend_addr : req_pc + 32'd4;
                    pend_valid <= 1'b0;
                end
                if (rsp_ok && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    if (instr_err_i) begin
                        state <= HALT;
                    end
                end
                // Redirect overrides the updates above; a held request is
                // replayed at its old address and its response counted as stale.
                if (redirect) begin
                    state   <= RUN;
                    resp_pc <= branch_tgt;
                    if (held_now) begin
                        pend_valid  <= 1'b1;
                        pend_addr   <= branch_tgt;
                        discard_cnt <= outstanding_nxt + CW'(1);
                    end else begin
                        req_pc      <= branch_tgt;
                        pend_valid  <= 1'b0;
                        discard_cnt <= outstanding_nxt;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && instr_rvalid_i) begin
            assert (outstanding != '0)
            else $error("if_fetch_req: rvalid with no outstanding request");
        end
    end

    if_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(redirect),
        .push_i (push),
        .wdata_i(push_entry),
        .pop_i  (pop),
        .head_o (head),
        .count_o(fifo_count)
    );

endmodule
